// File: rtl/fp_add_normaliser_pkg.sv
// Shared definitions for the FP32 adder normalise/round stage:
// field widths, packed special values and FSM state encodings.
package fp_add_normaliser_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int MANT_W = 49;

  localparam logic [EXP_W-1:0] EXP_INF = 8'hFF;
  localparam logic [31:0]      QNAN    = 32'h7FC00000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SUM   = 3'd1,
    ST_NORM  = 3'd2,
    ST_ROUND = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  function automatic logic [31:0] pack_inf(input logic sign);
    return {sign, EXP_INF, 23'h000000};
  endfunction

  function automatic logic [31:0] pack_zero(input logic sign);
    return {sign, 31'h00000000};
  endfunction

endpackage

// File: rtl/fp_add_normaliser_lzc49.sv
// Combinational leading-zero count of a 48-bit vector; all-zero input gives 48.
module fp_add_normaliser_lzc49 (
  input  logic [47:0] i_vec,
  output logic [5:0]  o_cnt
);

  // Scan LSB to MSB so the highest set bit has the final say.
  always_comb begin
    o_cnt = 6'd48;
    for (int i = 0; i < 48; i++) begin
      o_cnt = i_vec[i] ? 6'(47 - i) : o_cnt;
    end
  end

endmodule

// File: rtl/fp_add_normaliser.sv
// FP32 adder stage 2: sums the aligned mantissas, normalises a few bits per cycle,
// rounds to nearest-even and packs the IEEE-754 single, with valid/ready on both sides.
module fp_add_normaliser
  import fp_add_normaliser_pkg::*;
#(
  parameter int SHIFT_STEP = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              NaN_res,
  input  logic              inf_res,
  input  logic              res_sig,
  input  logic              legal,
  input  logic [EXP_W-1:0]  exp_max,
  input  logic [MANT_W-1:0] mant_op_1,
  input  logic [MANT_W-1:0] mant_op_2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       result
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [31:0]       r_result;
  logic [MANT_W-1:0] r_mant_1;
  logic [MANT_W-1:0] r_mant_2;
  logic [MANT_W-1:0] r_s;
  logic [EXP_W:0]    r_e;
  logic              r_sticky;
  logic              r_sign;

  // One extra bit keeps the two's-complement sum from wrapping before the magnitude is taken.
  logic [MANT_W:0]   w_sum;
  logic [MANT_W-1:0] w_abs;
  logic              w_abs_zero;

  assign w_sum      = {r_mant_1[MANT_W-1], r_mant_1} + {r_mant_2[MANT_W-1], r_mant_2};
  assign w_abs      = w_sum[MANT_W] ? MANT_W'(-w_sum) : w_sum[MANT_W-1:0];
  assign w_abs_zero = (w_abs == {MANT_W{1'b0}});

  logic [5:0]     w_lzc;
  logic [EXP_W:0] w_e_m1;
  logic [EXP_W:0] w_k_step;
  logic [EXP_W:0] w_k;

  fp_add_normaliser_lzc49 u_lzc (
    .i_vec (r_s[47:0]),
    .o_cnt (w_lzc)
  );

  // Shift is capped by the per-cycle budget and by how far E can drop before going subnormal.
  assign w_e_m1   = r_e - 9'd1;
  assign w_k_step = ({3'b000, w_lzc} < 9'(SHIFT_STEP)) ? {3'b000, w_lzc} : 9'(SHIFT_STEP);
  assign w_k      = (w_k_step < w_e_m1) ? w_k_step : w_e_m1;

  logic [FRAC_W-1:0] w_frac;
  logic              w_guard;
  logic              w_stick_all;
  logic              w_round_up;
  logic [24:0]       w_mant_rnd;
  logic [EXP_W:0]    w_e_rnd;
  logic              w_hidden;
  logic [FRAC_W-1:0] w_frac_rnd;
  logic [31:0]       w_rounded;

  assign w_frac      = r_s[46:24];
  assign w_guard     = r_s[23];
  assign w_stick_all = (|r_s[22:0]) | r_sticky;
  assign w_round_up  = w_guard & (w_stick_all | w_frac[0]);
  assign w_mant_rnd  = {1'b0, r_s[47], w_frac} + {24'h000000, w_round_up};

  // Rounding carry renormalises to 1.0 with a bumped exponent; overflow saturates to infinity.
  always_comb begin
    w_e_rnd    = r_e;
    w_hidden   = w_mant_rnd[23];
    w_frac_rnd = w_mant_rnd[22:0];
    w_rounded  = pack_zero(r_sign);
    if (w_mant_rnd[24]) begin
      w_e_rnd    = r_e + 9'd1;
      w_hidden   = 1'b1;
      w_frac_rnd = 23'h000000;
    end else begin
      w_e_rnd    = r_e;
    end
    if (w_e_rnd >= 9'd255) begin
      w_rounded = pack_inf(r_sign);
    end else begin
      w_rounded = {r_sign, (w_hidden ? w_e_rnd[EXP_W-1:0] : 8'h00), w_frac_rnd};
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_state_nxt = legal ? ST_SUM : ST_DONE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SUM:   w_state_nxt = w_abs_zero ? ST_DONE : ST_NORM;
      ST_NORM: begin
        if (r_s == {MANT_W{1'b0}}) begin
          w_state_nxt = ST_DONE;
        end else if (r_s[48] || r_s[47] || (r_e == 9'd1)) begin
          w_state_nxt = ST_ROUND;
        end else begin
          w_state_nxt = ST_NORM;
        end
      end
      ST_ROUND: w_state_nxt = ST_DONE;
      ST_DONE: begin
        if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // State register, handshake flags and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= 32'h00000000;
      r_mant_1    <= {MANT_W{1'b0}};
      r_mant_2    <= {MANT_W{1'b0}};
      r_s         <= {MANT_W{1'b0}};
      r_e         <= 9'd0;
      r_sticky    <= 1'b0;
      r_sign      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == ST_IDLE);
      r_out_valid <= (w_state_nxt == ST_DONE);
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_sign   <= res_sig;
            r_mant_1 <= mant_op_1;
            r_mant_2 <= mant_op_2;
            r_e      <= (exp_max == 8'h00) ? 9'd1 : {1'b0, exp_max};
            r_sticky <= 1'b0;
            if (NaN_res) begin
              r_result <= QNAN;
            end else if (inf_res) begin
              r_result <= pack_inf(res_sig);
            end else begin
              r_result <= pack_zero(res_sig);
            end
          end
        end
        ST_SUM: begin
          r_s <= w_abs;
          if (w_abs_zero) begin
            r_result <= pack_zero(r_sign);
          end
        end
        ST_NORM: begin
          if (r_s == {MANT_W{1'b0}}) begin
            r_result <= pack_zero(r_sign);
          end else if (r_s[48]) begin
            r_s      <= r_s >> 1;
            r_sticky <= r_sticky | r_s[0];
            r_e      <= r_e + 9'd1;
          end else if (!r_s[47] && (r_e != 9'd1)) begin
            r_s <= r_s << w_k;
            r_e <= r_e - w_k;
          end
        end
        ST_ROUND: r_result <= w_rounded;
        ST_DONE:  r_result <= r_result;
        default:  r_result <= r_result;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;

endmodule

// File: tb/tb_fp_add_normaliser.sv
// Directed-vector bench for fp_add_normaliser with hand-computed results and latencies.
module tb_fp_add_normaliser;

  logic        clk       = 1'b0;
  logic        rst       = 1'b1;
  logic        in_valid  = 1'b0;
  logic        NaN_res   = 1'b0;
  logic        inf_res   = 1'b0;
  logic        res_sig   = 1'b0;
  logic        legal     = 1'b0;
  logic        out_ready = 1'b0;
  logic [7:0]  exp_max   = 8'h00;
  logic [48:0] mant_op_1 = 49'h0;
  logic [48:0] mant_op_2 = 49'h0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] result;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  fp_add_normaliser #(.SHIFT_STEP(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .NaN_res   (NaN_res),
    .inf_res   (inf_res),
    .res_sig   (res_sig),
    .legal     (legal),
    .exp_max   (exp_max),
    .mant_op_1 (mant_op_1),
    .mant_op_2 (mant_op_2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic issue(input logic lg, input logic nan, input logic inf, input logic sg,
                       input logic [7:0] em, input logic [48:0] m1, input logic [48:0] m2);
    int guard = 0;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    check_val("in_ready_before_issue", 32'(in_ready), 32'h1);
    legal     = lg;
    NaN_res   = nan;
    inf_res   = inf;
    res_sig   = sg;
    exp_max   = em;
    mant_op_1 = m1;
    mant_op_2 = m2;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
  endtask

  task automatic wait_result(output logic [31:0] res, output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result;
  endtask

  task automatic run_vec(input string tag, input logic lg, input logic nan, input logic inf,
                         input logic sg, input logic [7:0] em, input logic [48:0] m1,
                         input logic [48:0] m2, input logic [31:0] exp_res, input int exp_lat);
    logic [31:0] res;
    int          lat;
    issue(lg, nan, inf, sg, em, m1, m2);
    wait_result(res, lat);
    check_val({tag, "_result"}, res, exp_res);
    check_val({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_val({tag, "_after_hs"}, 32'({in_ready, out_valid}), 32'h2);
  endtask

  initial begin
    logic [31:0] res;
    int          lat;
    int          stray_valid;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_val("reset_in_ready", 32'(in_ready), 32'h1);
    check_val("reset_out_valid", 32'(out_valid), 32'h0);
    check_val("reset_result", result, 32'h00000000);

    run_vec("one_plus_one",  1'b1, 1'b0, 1'b0, 1'b0, 8'd127, 49'h0800000000000, 49'h0800000000000, 32'h40000000, 4);
    run_vec("onefive_m_one", 1'b1, 1'b0, 1'b0, 1'b0, 8'd127, 49'h0C00000000000, 49'h1800000000000, 32'h3F000000, 5);
    run_vec("one_m_onefive", 1'b1, 1'b0, 1'b0, 1'b1, 8'd127, 49'h1800000000000, 49'h0C00000000000, 32'hBF000000, 5);
    run_vec("x_minus_x",     1'b1, 1'b0, 1'b0, 1'b0, 8'd127, 49'h0800000000000, 49'h1800000000000, 32'h00000000, 2);
    run_vec("overflow",      1'b1, 1'b0, 1'b0, 1'b0, 8'd254, 49'h0800000000000, 49'h0800000000000, 32'h7F800000, 4);
    run_vec("tie_even_down", 1'b1, 1'b0, 1'b0, 1'b0, 8'd127, 49'h0800000800000, 49'h0000000000000, 32'h3F800000, 4);
    run_vec("tie_odd_up",    1'b1, 1'b0, 1'b0, 1'b0, 8'd127, 49'h0800001800000, 49'h0000000000000, 32'h3F800002, 4);
    run_vec("subnormal",     1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   49'h0400000000000, 49'h0000000000000, 32'h00400000, 4);
    run_vec("bypass_nan",    1'b0, 1'b1, 1'b0, 1'b0, 8'd0,   49'h0, 49'h0, 32'h7FC00000, 1);
    run_vec("bypass_ninf",   1'b0, 1'b0, 1'b1, 1'b1, 8'd0,   49'h0, 49'h0, 32'hFF800000, 1);

    // Hold the result under backpressure.
    issue(1'b1, 1'b0, 1'b0, 1'b0, 8'd127, 49'h0800000000000, 49'h0800000000000);
    wait_result(res, lat);
    check_val("bp_first", res, 32'h40000000);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_val("bp_result_stable", result, 32'h40000000);
      check_val("bp_flags", 32'({in_ready, out_valid}), 32'h1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_val("bp_release", 32'({in_ready, out_valid}), 32'h2);

    // Asynchronous reset while the operand is still being normalised.
    issue(1'b1, 1'b0, 1'b0, 1'b0, 8'd127, 49'h0000000000001, 49'h0000000000000);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_val("abort_flags", 32'({in_ready, out_valid}), 32'h2);
    check_val("abort_result", result, 32'h00000000);
    @(posedge clk); #1 rst = 1'b0;
    stray_valid = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (out_valid) stray_valid++;
    end
    check_val("abort_no_stray_valid", 32'(stray_valid), 32'h0);
    check_val("abort_in_ready", 32'(in_ready), 32'h1);

    run_vec("after_abort",   1'b1, 1'b0, 1'b0, 1'b0, 8'd127, 49'h0800000000000, 49'h0800000000000, 32'h40000000, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
